// File: rtl/ipsxe_floating_point_sqrt_arb_v1_0_pkg.sv
// Shared helpers for the sqrt arbiter: ceiling log2 and the default tag width.
package ipsxe_floating_point_sqrt_arb_v1_0_pkg;

  // Ceiling log2, never below 1, so a 2-entry index still gets a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_TAG_W   = clog2(DEF_NUM_REQ);

endpackage

// File: rtl/ipsxe_floating_point_sqrt_arb_v1_0_rr.sv
// Round-robin picker: first requester above last_grant, wrapping, one-hot out.
module ipsxe_floating_point_rr_arb_v1_0
  import ipsxe_floating_point_sqrt_arb_v1_0_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [clog2(NUM_REQ)-1:0] last_grant,
  input  logic                      en,
  output logic [NUM_REQ-1:0]        grant_c
);

  localparam int unsigned TAG_W = clog2(NUM_REQ);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant_c = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant) + i) % NUM_REQ;
      if (en && !found && req[idx[TAG_W-1:0]]) begin
        grant_c[idx[TAG_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_sqrt_arb_v1_0.sv
// Shares one pipelined sqrt mantissa core among NUM_REQ requesters; results
// return in issue order through a credit-protected show-ahead FIFO.
module ipsxe_floating_point_sqrt_arb_v1_0
  import ipsxe_floating_point_sqrt_arb_v1_0_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
  parameter int unsigned BINARY_SIZE   = 48,
  parameter int unsigned MANTISSA_SIZE = 23,
  parameter int unsigned CORE_LATENCY  = 3,
  parameter int unsigned RSP_DEPTH     = 5
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_aclken,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*BINARY_SIZE-1:0]   i_req_man,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic [BINARY_SIZE-1:0]           o_core_man,
  input  logic [MANTISSA_SIZE-1:0]         i_core_sqrt_man,
  output logic                             o_rsp_valid,
  input  logic                             i_rsp_ready,
  output logic [clog2(NUM_REQ)-1:0]        o_rsp_tag,
  output logic [MANTISSA_SIZE-1:0]         o_rsp_man,
  output logic                             o_busy
);

  localparam int unsigned TAG_W = clog2(NUM_REQ);
  localparam int unsigned PTR_W = clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = clog2(RSP_DEPTH + 1);

  generate
    if (RSP_DEPTH < CORE_LATENCY + 2) begin : g_depth_chk
      $error("RSP_DEPTH must be at least CORE_LATENCY+2");
    end
  endgenerate

  logic [CNT_W-1:0]         credit;
  logic [TAG_W-1:0]         last_grant;
  logic [TAG_W-1:0]         gnt_tag;
  logic [NUM_REQ-1:0]       grant_c;
  logic                     issue_ok;
  logic                     issue;
  logic                     pop;
  logic                     push;
  logic                     op_vld_q;
  logic [TAG_W-1:0]         op_tag_q;
  logic [CORE_LATENCY-1:0]  sr_vld;
  logic [TAG_W-1:0]         sr_tag [CORE_LATENCY];
  logic [TAG_W-1:0]         fifo_tag [RSP_DEPTH];
  logic [MANTISSA_SIZE-1:0] fifo_man [RSP_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         fifo_cnt;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A slot freed by this cycle's pop may be reused by this cycle's issue.
  assign pop      = o_rsp_valid & i_rsp_ready & i_aclken;
  assign issue_ok = (credit - CNT_W'(pop)) < CNT_W'(RSP_DEPTH);

  ipsxe_floating_point_rr_arb_v1_0 #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (i_req_valid),
    .last_grant (last_grant),
    .en         (issue_ok & i_aclken & ~i_rst),
    .grant_c    (grant_c)
  );

  assign o_req_ready = grant_c;
  assign issue       = |(grant_c & i_req_valid);

  always_comb begin
    gnt_tag = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_c[k]) gnt_tag = TAG_W'(k);
    end
  end

  assign push        = i_aclken & sr_vld[CORE_LATENCY-1];
  assign o_rsp_valid = (fifo_cnt != '0);
  assign o_rsp_tag   = o_rsp_valid ? fifo_tag[rd_ptr] : '0;
  assign o_rsp_man   = o_rsp_valid ? fifo_man[rd_ptr] : '0;
  assign o_busy      = (credit != '0);

  // Issue register plus tag/valid tracker aligned with the core's result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_core_man <= '0;
      last_grant <= TAG_W'(NUM_REQ - 1);
      op_vld_q   <= 1'b0;
      op_tag_q   <= '0;
      sr_vld     <= '0;
      for (int unsigned k = 0; k < CORE_LATENCY; k++) sr_tag[k] <= '0;
    end else if (i_aclken) begin
      op_vld_q <= issue;
      if (issue) begin
        o_core_man <= i_req_man[int'(gnt_tag)*BINARY_SIZE +: BINARY_SIZE];
        op_tag_q   <= gnt_tag;
        last_grant <= gnt_tag;
      end
      sr_vld[0] <= op_vld_q;
      sr_tag[0] <= op_tag_q;
      for (int unsigned k = 1; k < CORE_LATENCY; k++) begin
        sr_vld[k] <= sr_vld[k-1];
        sr_tag[k] <= sr_tag[k-1];
      end
    end
  end

  // Credit and FIFO bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      credit   <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (i_aclken) begin
      case ({issue, pop})
        2'b10:   credit <= credit + CNT_W'(1);
        2'b01:   credit <= credit - CNT_W'(1);
        default: credit <= credit;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_tag[wr_ptr] <= sr_tag[CORE_LATENCY-1];
      fifo_man[wr_ptr] <= i_core_sqrt_man;
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_sqrt_arb_v1_0.sv
// Directed + random bench for the sqrt arbiter with a transaction-level model.
module tb_ipsxe_floating_point_sqrt_arb_v1_0;

  localparam int N  = 4;
  localparam int BS = 48;
  localparam int MS = 23;
  localparam int L  = 3;
  localparam int D  = 5;

  logic            clk;
  logic            rst;
  logic            aclken;
  logic [N-1:0]    req_valid;
  logic [N*BS-1:0] req_man;
  logic [N-1:0]    req_ready;
  logic [BS-1:0]   core_man;
  logic [MS-1:0]   core_sqrt;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_tag;
  logic [MS-1:0]   rsp_man;
  logic            busy;

  ipsxe_floating_point_sqrt_arb_v1_0 dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_aclken        (aclken),
    .i_req_valid     (req_valid),
    .i_req_man       (req_man),
    .o_req_ready     (req_ready),
    .o_core_man      (core_man),
    .i_core_sqrt_man (core_sqrt),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_tag       (rsp_tag),
    .o_rsp_man       (rsp_man),
    .o_busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core stand-in: L enabled stages returning the low mantissa bits.
  logic [MS-1:0] pipe [L];
  always @(posedge clk) begin
    if (aclken) begin
      pipe[0] <= core_man[MS-1:0];
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign core_sqrt = pipe[L-1];

  typedef struct {
    int            tag;
    logic [MS-1:0] man;
    int            at;
  } op_t;

  op_t           q[$];
  int            last;
  int            ecnt;
  logic [BS-1:0] exp_core;
  logic          obs_gnt;
  int            total;
  int            bad;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int lg, input logic [N-1:0] v);
    for (int i = 1; i <= N; i++) begin
      if (v[2'((lg + i) % N)]) return (lg + i) % N;
    end
    return N;
  endfunction

  // Check outputs against the model for the current cycle, then advance one clock.
  task automatic step();
    int         g;
    logic [3:0] exp_rdy;
    logic       ev;
    logic       ep;
    #1;
    obs_gnt = (req_ready != '0);
    if (rst) begin
      chk("rst_ready", 64'(req_ready), 64'(0));
      q.delete();
      last     = N - 1;
      exp_core = '0;
    end else begin
      ev = (q.size() != 0) && (q[0].at <= ecnt);
      ep = ev && rsp_ready && aclken;
      g  = (aclken && (q.size() - int'(ep)) < D) ? rr_pick(last, req_valid) : N;
      exp_rdy = (g < N) ? 4'(1 << g) : 4'b0;
      chk("ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("core_man", 64'(core_man), 64'(exp_core));
      if (ev) begin
        chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
        chk("rsp_man", 64'(rsp_man), 64'(q[0].man));
      end
      chk("fifo_ovf", 64'(dut.push && (dut.fifo_cnt == 3'(D)) && !dut.pop), 64'(0));
      if (aclken) begin
        ecnt++;
        if (ep) void'(q.pop_front());
        if (g < N) begin
          exp_core = req_man[g*BS +: BS];
          q.push_back('{tag: g, man: req_man[g*BS +: MS], at: ecnt + L + 1});
          last = g;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_man();
    for (int k = 0; k < N; k++) req_man[k*BS +: BS] = 48'({$urandom(), $urandom()});
  endtask

  initial begin
    int n;
    int gcnt;
    total = 0; bad = 0; last = N - 1; ecnt = 0; exp_core = '0;
    rst = 1'b1; aclken = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    rand_man();

    // Reset with traffic present
    step(); step();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 64'(rsp_valid), 64'(0));
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("first_grant", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    repeat (8) step();

    // Single request latency and value
    req_man[1*BS +: BS] = 48'h000000ABCDEF;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 10) begin step(); n++; end
    chk("single_lat", 64'(n), 64'(4));
    chk("single_tag", 64'(rsp_tag), 64'(1));
    chk("single_man", 64'(rsp_man), 64'(23'h2BCDEF));
    repeat (3) step();

    // All valid, streaming
    req_valid = 4'hF;
    for (int i = 0; i < 20; i++) begin rand_man(); step(); end
    req_valid = '0;
    repeat (8) step();

    // Backpressure
    req_valid = 4'hF; rsp_ready = 1'b0; gcnt = 0;
    for (int i = 0; i < 15; i++) begin rand_man(); step(); if (obs_gnt) gcnt++; end
    chk("bp_grants", 64'(gcnt), 64'(5));
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin rand_man(); step(); end

    // Clock enable stall mid-stream
    aclken = 1'b0;
    repeat (3) begin rand_man(); step(); end
    aclken = 1'b1;
    for (int i = 0; i < 8; i++) begin rand_man(); step(); end
    req_valid = '0;
    repeat (8) step();

    // Reset with operations in flight
    req_valid = 4'hF;
    repeat (3) begin rand_man(); step(); end
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0;
    #1;
    chk("inflight_busy", 64'(busy), 64'(0));
    repeat (8) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom());
      aclken    = ($urandom_range(0, 9) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_man();
      step();
    end
    req_valid = '0; aclken = 1'b1; rsp_ready = 1'b1;
    repeat (12) step();
    chk("final_busy", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
